rf_clock_gate_bank: RTL and testbench
=====================================

// Module: rf_clock_gate_bank
// PURPOSE
// Glitch-free latch-based clock-gating bank for a latch-based register file.
// It has one global gate, enabled by the write enable, and it produces clk_global_o.
// clk_global_o feeds 2**AddrWidth per-word gates, each selected by a decoded write
// address; word 0 has its own enable for dummy-instruction writes.
// Each gate is a standard ICG: a low-transparent enable latch ANDed with the input clock.
// PARAMETERS
// AddrWidth  5  write-address width; number of word gates = 2**AddrWidth (RV32E: 4)
// HasWord0   0  1: gate 0 is driven by en_i & en0_i; 0: clk_o[0] tied low
// PORTS
// clk_i         in   1            free-running clock
// rst_i         in   1            async active-high reset; clears all enable latches
// test_en_i     in   1            scan/test enable; forces every gate open (not during reset)
// en_i          in   1            global write enable
// addr_i        in   AddrWidth    write address selecting the word gate
// en0_i         in   1            word-0 enable qualifier (dummy write); ignored if HasWord0=0
// clk_global_o  out  1            globally gated clock
// clk_o         out  2**AddrWidth per-word gated clocks; bit k for word k
// BEHAVIOUR
// - Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
// - ICG cell: latch en_q is transparent while its input clock is low, holds while high.
//   The cell outputs clk_out = clk_in & en_q.
//   An enable change while clk_in is high has no effect until the next low phase,
//   so the output never glitches or truncates a pulse.
// - Global gate: clk_in=clk_i, en = en_i | test_en_i -> clk_global_o.
// - Word gate k (1..2**AddrWidth-1): clk_in=clk_global_o.
//   Its enable is (en_i && addr_i==k) | test_en_i.
// - Word gate 0: enable is (en_i & en0_i) | test_en_i when HasWord0=1.
//   addr_i is not compared for word 0.
//   When HasWord0=0, clk_o[0] is constant 0.
// - Latency: en_i/addr_i stable during the low phase before posedge N.
//   clk_global_o and the one selected clk_o[k] then pulse high for the high phase of cycle N.
//   Each output is exactly one pulse, coincident with clk_i high.
//   All other clk_o bits stay low.
// - Timing: the word gates use clk_global_o as their input clock and latch during its low phase.
//   clk_global_o is low whenever clk_i is low, so word enables are sampled in the same low phase.
//   This gives no extra latency.
// - At most one clk_o bit pulses per cycle, unless test_en_i=1.
//   With en0_i=1, en_i=1 and addr_i=k!=0, gates 0 and k both pulse; this is permitted.
// - Reset: while rst_i=1, all en_q=0 asynchronously, so clk_global_o=0 and clk_o=0.
//   test_en_i does not override reset.
//   If reset is asserted mid-pulse, the output drops immediately.
//   After rst_i falls, the first pulse occurs in the first clk_i high phase
//   whose preceding low phase saw the enable.
// - addr_i out of range cannot occur; the full 2**AddrWidth decode is mandatory.
// - No flip-flops are used.
// - The latch is behavioural (always_latch); a target-library ICG may be substituted
//   per gate without changing the ports.
// TESTING
// - Reset: rst_i=1 with en_i=1, test_en_i=1 -> clk_global_o=0 and clk_o=0 for 3 cycles.
// - Single write: en_i=1, addr_i=5 held in one low phase -> one pulse on clk_global_o and clk_o[5].
//   All other bits stay 0; with en_i=0 the next cycle, no pulses.
// - Glitch check: toggle en_i 0->1->0 during the clk_i high phase -> no pulse that cycle.
// - Address change while high: addr 3->9 mid-high phase -> only clk_o[3] pulses fully, with no runt.
//   clk_o[9] pulses the next cycle if still enabled.
// - Word 0 (HasWord0=1): en_i=1, en0_i=1, addr_i=0 -> clk_o[0] pulses.
//   en0_i=0, addr_i=0 -> clk_o[0] does not pulse.
//   With HasWord0=0, clk_o[0] is always 0.
// - Test mode: test_en_i=1, en_i=0 -> clk_global_o and all enabled clk_o bits follow clk_i every cycle.
//   Mid-pulse reset assertion -> all outputs go low immediately.

Source files
------------

// File: rtl/rf_clock_gate_bank_if.sv
// Enable/address bundle into the register-file clock-gate bank and the gated clocks it returns.
// master drives the write request; slave is the gate bank.
interface rf_clock_gate_bank_if #(
  parameter int unsigned AddrWidth = 5
);
  localparam int unsigned NumWords = 2 ** AddrWidth;

  logic                 test_en_i;
  logic                 en_i;
  logic [AddrWidth-1:0] addr_i;
  logic                 en0_i;
  logic                 clk_global_o;
  logic [NumWords-1:0]  clk_o;

  modport master (
    output test_en_i, en_i, addr_i, en0_i,
    input  clk_global_o, clk_o
  );

  modport slave (
    input  test_en_i, en_i, addr_i, en0_i,
    output clk_global_o, clk_o
  );
endinterface

// File: rtl/rf_clock_gate_bank.sv
// Latch-based ICG bank: one global gate on clk_i feeding one word gate per register-file word.
// Every enable latch is transparent while its input clock is low, so the gated pulses cannot glitch.
module rf_clock_gate_bank #(
  parameter int unsigned AddrWidth = 5,
  parameter bit          HasWord0  = 1'b0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rf_clock_gate_bank_if.slave bus
);
  localparam int unsigned NumWords = 2 ** AddrWidth;

  logic                glob_en_d;
  logic                glob_en_q;
  logic                clk_global;
  logic [NumWords-1:0] word_en_d;
  logic [NumWords-1:0] word_en_q;

  assign glob_en_d = bus.en_i | bus.test_en_i;

  always_latch begin
    if (rst_i) begin
      glob_en_q <= 1'b0;
    end else if (!clk_i) begin
      glob_en_q <= glob_en_d;
    end
  end

  assign clk_global = clk_i & glob_en_q;

  always_comb begin
    word_en_d = '0;
    for (int unsigned k = 1; k < NumWords; k++) begin
      word_en_d[k] = (bus.en_i && (bus.addr_i == AddrWidth'(k))) || bus.test_en_i;
    end
    // Word 0 is qualified only by the dummy-write enable; the address is not compared.
    if (HasWord0) begin
      word_en_d[0] = (bus.en_i & bus.en0_i) | bus.test_en_i;
    end
  end

  // clk_global is low whenever clk_i is low, so these latches sample in the same low phase.
  always_latch begin
    if (rst_i) begin
      word_en_q <= '0;
    end else if (!clk_global) begin
      word_en_q <= word_en_d;
    end
  end

  assign bus.clk_global_o = clk_global;
  assign bus.clk_o        = {NumWords{clk_global}} & word_en_q;
endmodule

// File: tb/tb_rf_clock_gate_bank.sv
// Directed bench for rf_clock_gate_bank: two instances (word-0 gate present / absent) on shared stimulus.
// Expected {clk_global_o, clk_o} per high phase is queued when inputs are driven and checked when sampled.
module tb_rf_clock_gate_bank;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp1_q[$];
  logic [32:0] exp2_q[$];

  rf_clock_gate_bank_if #(.AddrWidth(5)) bus1 ();
  rf_clock_gate_bank_if #(.AddrWidth(5)) bus2 ();

  assign bus2.test_en_i = bus1.test_en_i;
  assign bus2.en_i      = bus1.en_i;
  assign bus2.addr_i    = bus1.addr_i;
  assign bus2.en0_i     = bus1.en0_i;

  rf_clock_gate_bank #(.AddrWidth(5), .HasWord0(1'b1)) dut_w0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus1)
  );

  rf_clock_gate_bank #(.AddrWidth(5), .HasWord0(1'b0)) dut_nw0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus2)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [32:0] model(input logic rst, input logic en, input logic [4:0] addr,
                                        input logic en0, input logic test, input bit hw0);
    logic [32:0] r;
    r = '0;
    if (!rst) begin
      r[32] = en | test;
      for (int k = 1; k < 32; k++) r[k] = (en && (addr == 5'(k))) || test;
      if (hw0) r[0] = (en & en0) | test;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends in the clk_i low phase. mid: 0 none, 1 change en/addr mid-high, 2 pulse en mid-high.
  task automatic cycle(input string tag, input logic rst_v, input logic en_v, input logic [4:0] addr_v,
                       input logic en0_v, input logic test_v,
                       input int mid, input logic mid_en, input logic [4:0] mid_addr);
    logic [32:0] e1, e2;
    rst_i          = rst_v;
    bus1.en_i      = en_v;
    bus1.addr_i    = addr_v;
    bus1.en0_i     = en0_v;
    bus1.test_en_i = test_v;
    exp1_q.push_back(model(rst_v, en_v, addr_v, en0_v, test_v, 1'b1));
    exp2_q.push_back(model(rst_v, en_v, addr_v, en0_v, test_v, 1'b0));
    @(posedge clk_i);
    #1;
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    check({tag, "_hi"}, {bus1.clk_global_o, bus1.clk_o}, e1);
    check({tag, "_hi_nw0"}, {bus2.clk_global_o, bus2.clk_o}, e2);
    if (mid == 1) begin
      #1;
      bus1.en_i   = mid_en;
      bus1.addr_i = mid_addr;
      #2;
    end else if (mid == 2) begin
      #1 bus1.en_i = mid_en;
      #1 bus1.en_i = en_v;
      #1;
    end else begin
      #3;
    end
    check({tag, "_hi_late"}, {bus1.clk_global_o, bus1.clk_o}, e1);
    @(negedge clk_i);
    #1;
    check({tag, "_lo"}, {bus1.clk_global_o, bus1.clk_o}, 33'h0);
    check({tag, "_lo_nw0"}, {bus2.clk_global_o, bus2.clk_o}, 33'h0);
  endtask

  initial begin
    bus1.en_i      = 1'b1;
    bus1.addr_i    = 5'd0;
    bus1.en0_i     = 1'b0;
    bus1.test_en_i = 1'b1;

    for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 0, 1'b0, 5'd0);

    // Reset release: first pulse in the first high phase after the enabled low phase.
    cycle("rst_release", 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("write5", 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("idle", 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("write31", 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("glitch", 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 2, 1'b1, 5'd12);
    cycle("addr3to9", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1, 1'b1, 5'd9);
    cycle("addr9", 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("drop_en_hi", 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1, 1'b0, 5'd2);
    cycle("word0", 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd0);
    cycle("word0_noen0", 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    cycle("word0_and4", 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 0, 1'b0, 5'd0);
    cycle("en0_only", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) cycle("test_mode", 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 0, 1'b0, 5'd0);

    // Reset asserted in the middle of a test-mode pulse drops every output at once.
    rst_i          = 1'b0;
    bus1.en_i      = 1'b0;
    bus1.test_en_i = 1'b1;
    exp1_q.push_back(model(1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1));
    @(posedge clk_i);
    #1;
    check("midrst_before", {bus1.clk_global_o, bus1.clk_o}, exp1_q.pop_front());
    #1 rst_i = 1'b1;
    #1;
    check("midrst_after", {bus1.clk_global_o, bus1.clk_o}, 33'h0);
    check("midrst_after_nw0", {bus2.clk_global_o, bus2.clk_o}, 33'h0);
    @(negedge clk_i);
    #1;

    cycle("held_rst_test", 1'b1, 1'b0, 5'd6, 1'b0, 1'b1, 0, 1'b0, 5'd0);
    cycle("after_rst", 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      automatic logic [4:0] a = 5'($urandom_range(1, 31));
      cycle("rand_write", 1'b0, 1'b1, a, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 5'd0);
    end
    cycle("final_idle", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 5'd0);

    if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp1_q.size() + exp2_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
